// File: rtl/uart_div_frame_ctrl_if.sv
// Byte handshake bundle between the UART pair and the divide controller.
// The slave side is the controller; the master side drives RX bytes and TX ready.
interface uart_div_frame_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/uart_div_frame_ctrl.sv
// Collects A and B little-endian from a byte stream, divides A / B with a
// sequential restoring divider and streams Q then R back out.
module uart_div_frame_ctrl #(
    parameter int OP_BYTES    = 2,
    parameter int GAP_TIMEOUT = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_div_frame_ctrl_if.slave    bus,
    output logic [8*OP_BYTES-1:0]   result_q,
    output logic [8*OP_BYTES-1:0]   result_r,
    output logic                    div_zero,
    output logic                    frame_err,
    output logic                    busy
);
    localparam int W  = 8 * OP_BYTES;
    localparam int NB = 2 * OP_BYTES;
    localparam int CW = $clog2(NB);
    localparam int BW = $clog2(W);
    localparam int GW = $clog2(GAP_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RX   = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_TX   = 2'd3;

    if (OP_BYTES < 1 || OP_BYTES > 4) begin : g_bad_op
        $error("OP_BYTES must be 1..4");
    end
    if (GAP_TIMEOUT < 2) begin : g_bad_gap
        $error("GAP_TIMEOUT must be >= 2");
    end

    logic [1:0]    state;
    logic [CW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2*W-1:0] opnd;
    logic [2*W-1:0] opnd_nx;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] tx_idx;
    logic          tx_valid_q;
    logic [7:0]    tx_byte;

    logic [W-1:0] a_op;
    logic [W-1:0] b_op;
    logic [W:0]   shifted;
    logic [W-1:0] trial;
    logic         take;
    logic [W-1:0] rem_nx;
    logic [W-1:0] quo_nx;
    logic [2*W-1:0] tx_bytes;

    assign a_op = opnd[W-1:0];
    assign b_op = opnd[2*W-1:W];

    // W+1-bit partial remainder; the difference fits W bits whenever taken.
    assign shifted = {rem, quo[W-1]};
    assign take    = shifted >= {1'b0, b_op};
    assign trial   = shifted[W-1:0] - b_op;
    assign rem_nx  = take ? trial : shifted[W-1:0];
    assign quo_nx  = {quo[W-2:0], take};

    always_comb begin
        opnd_nx = opnd;
        for (int i = 0; i < NB; i++) begin
            if (byte_cnt == CW'(i)) begin
                opnd_nx[8*i +: 8] = bus.rx_data;
            end
        end
    end

    assign tx_bytes = {result_r, result_q};

    always_comb begin
        tx_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (tx_idx == CW'(i)) begin
                tx_byte = tx_bytes[8*i +: 8];
            end
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_valid_q ? tx_byte : 8'h00;
    assign busy = (state == S_DIV) || (state == S_TX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            opnd       <= '0;
            rem        <= '0;
            quo        <= '0;
            bit_cnt    <= '0;
            tx_idx     <= '0;
            tx_valid_q <= 1'b0;
            result_q   <= '0;
            result_r   <= '0;
            div_zero   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        opnd     <= {{(2*W-8){1'b0}}, bus.rx_data};
                        byte_cnt <= CW'(1);
                        gap_cnt  <= '0;
                        state    <= S_RX;
                    end
                end
                S_RX: begin
                    if (bus.rx_valid) begin
                        opnd    <= opnd_nx;
                        gap_cnt <= '0;
                        if (byte_cnt == CW'(NB-1)) begin
                            byte_cnt <= '0;
                            rem      <= '0;
                            quo      <= a_op;
                            bit_cnt  <= '0;
                            state    <= S_DIV;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end else if (gap_cnt == GW'(GAP_TIMEOUT-1)) begin
                        frame_err <= 1'b1;
                        opnd      <= '0;
                        byte_cnt  <= '0;
                        gap_cnt   <= '0;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_DIV: begin
                    if (b_op == '0) begin
                        result_q   <= '1;
                        result_r   <= a_op;
                        div_zero   <= 1'b1;
                        tx_idx     <= '0;
                        tx_valid_q <= 1'b1;
                        state      <= S_TX;
                    end else begin
                        rem     <= rem_nx;
                        quo     <= quo_nx;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(W-1)) begin
                            result_q   <= quo_nx;
                            result_r   <= rem_nx;
                            div_zero   <= 1'b0;
                            tx_idx     <= '0;
                            tx_valid_q <= 1'b1;
                            state      <= S_TX;
                        end
                    end
                end
                S_TX: begin
                    if (tx_valid_q && bus.tx_ready) begin
                        if (tx_idx == CW'(NB-1)) begin
                            tx_idx     <= '0;
                            tx_valid_q <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            tx_idx <= tx_idx + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_div_frame_ctrl.sv
// Bench for uart_div_frame_ctrl: OP_BYTES=2 and OP_BYTES=3 instances checked
// every cycle against a queue-based frame model, plus literal expectations.
`timescale 1ns/1ps
module tb_uart_div_frame_ctrl;
    localparam int GAP = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       rxv = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       txr = 1'b1;
    logic [1:0] en  = 2'b01;
    int         cyc = 0;
    int         rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    uart_div_frame_ctrl_if b2 ();
    uart_div_frame_ctrl_if b3 ();

    assign b2.rx_valid = rxv & en[0];
    assign b2.rx_data  = rxd;
    assign b2.tx_ready = txr;
    assign b3.rx_valid = rxv & en[1];
    assign b3.rx_data  = rxd;
    assign b3.tx_ready = txr;

    logic [15:0] q2, r2;
    logic [23:0] q3, r3;
    logic [1:0]  dz, fe, bs;

    uart_div_frame_ctrl #(.OP_BYTES(2), .GAP_TIMEOUT(GAP)) u2 (
        .clk(clk), .rst(rst), .bus(b2),
        .result_q(q2), .result_r(r2),
        .div_zero(dz[0]), .frame_err(fe[0]), .busy(bs[0])
    );

    uart_div_frame_ctrl #(.OP_BYTES(3), .GAP_TIMEOUT(GAP)) u3 (
        .clk(clk), .rst(rst), .bus(b3),
        .result_q(q3), .result_r(r3),
        .div_zero(dz[1]), .frame_err(fe[1]), .busy(bs[1])
    );

    logic [1:0]  tv;
    logic [7:0]  td [2];
    logic [31:0] oq [2];
    logic [31:0] orr [2];
    assign tv[0]  = b2.tx_valid;
    assign tv[1]  = b3.tx_valid;
    assign td[0]  = b2.tx_data;
    assign td[1]  = b3.tx_data;
    assign oq[0]  = {16'h0, q2};
    assign oq[1]  = {8'h0, q3};
    assign orr[0] = {16'h0, r2};
    assign orr[1] = {8'h0, r3};

    // Reference model: bytes gathered into a queue, quotient by plain arithmetic,
    // a countdown for the divide time and a queue of bytes still to be sent.
    logic [7:0]  mq  [2][$];
    logic [7:0]  mtx [2][$];
    int          midle [2];
    int          mdiv  [2];
    logic [31:0] mqv [2];
    logic [31:0] mrv [2];
    logic        mdz [2];
    logic        mfe [2];
    longint unsigned pq [2];
    longint unsigned pr [2];
    logic        pdz [2];

    function automatic int nbytes(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic model_step(int k);
        int n;
        longint unsigned a, b, mask;
        n = nbytes(k);
        mfe[k] = 1'b0;
        if (!rst) begin
            mq[k].delete();
            mtx[k].delete();
            midle[k] = 0;
            mdiv[k]  = 0;
            mqv[k]   = 0;
            mrv[k]   = 0;
            mdz[k]   = 1'b0;
        end else if (mtx[k].size() > 0) begin
            if (txr) void'(mtx[k].pop_front());
        end else if (mdiv[k] > 0) begin
            mdiv[k]--;
            if (mdiv[k] == 0) begin
                mqv[k] = 32'(pq[k]);
                mrv[k] = 32'(pr[k]);
                mdz[k] = pdz[k];
                for (int i = 0; i < n; i++) mtx[k].push_back(8'(pq[k] >> (8*i)));
                for (int i = 0; i < n; i++) mtx[k].push_back(8'(pr[k] >> (8*i)));
            end
        end else if (rxv && en[k]) begin
            mq[k].push_back(rxd);
            midle[k] = 0;
            if (mq[k].size() == 2*n) begin
                a = 0;
                b = 0;
                for (int i = 0; i < n; i++) begin
                    a |= 64'(mq[k][i]) << (8*i);
                    b |= 64'(mq[k][n+i]) << (8*i);
                end
                mask   = (64'd1 << (8*n)) - 1;
                pdz[k] = (b == 0);
                pq[k]  = (b == 0) ? mask : a / b;
                pr[k]  = (b == 0) ? a : a % b;
                mdiv[k] = (b == 0) ? 1 : 8*n;
                mq[k].delete();
            end
        end else if (mq[k].size() > 0) begin
            midle[k]++;
            if (midle[k] == GAP) begin
                mfe[k] = 1'b1;
                mq[k].delete();
                midle[k] = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            midle[k] = 0; mdiv[k] = 0; mqv[k] = 0; mrv[k] = 0;
            mdz[k] = 0; mfe[k] = 0; pq[k] = 0; pr[k] = 0; pdz[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cap [2][$];
    int fe_cnt [2] = '{0, 0};
    int lrx [2] = '{0, 0};
    int ftx [2] = '{0, 0};
    logic [1:0] ptv = 2'b00;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [7:0] eh;
        for (int k = 0; k < 2; k++) begin
            eh = (mtx[k].size() > 0) ? mtx[k][0] : 8'h00;
            chk($sformatf("u%0d.tx_valid", k), 32'(tv[k]), 32'(mtx[k].size() > 0));
            chk($sformatf("u%0d.tx_data", k), 32'(td[k]), 32'(eh));
            chk($sformatf("u%0d.busy", k), 32'(bs[k]),
                32'((mdiv[k] > 0) || (mtx[k].size() > 0)));
            chk($sformatf("u%0d.frame_err", k), 32'(fe[k]), 32'(mfe[k]));
            chk($sformatf("u%0d.result_q", k), oq[k], mqv[k]);
            chk($sformatf("u%0d.result_r", k), orr[k], mrv[k]);
            chk($sformatf("u%0d.div_zero", k), 32'(dz[k]), 32'(mdz[k]));
            if (tv[k] && txr) cap[k].push_back(td[k]);
            if (fe[k]) fe_cnt[k]++;
            if (rxv && en[k]) lrx[k] = cyc;
            if (tv[k] && !ptv[k]) ftx[k] = cyc;
        end
        ptv = tv;
    endtask

    task automatic step();
        case (rdy_mode)
            0: txr = 1'b1;
            1: txr = (cyc % 3 == 0);
            2: txr = 1'($urandom_range(0, 1));
            default: ;
        endcase
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        rxv = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(logic [7:0] d);
        rxv = 1'b1;
        rxd = d;
        step();
        rxv = 1'b0;
    endtask

    task automatic send_frame(logic [47:0] v, int n);
        for (int i = 0; i < n; i++) send(v[8*i +: 8]);
    endtask

    task automatic wait_done(int k);
        int i;
        i = 0;
        step();
        while (bs[k] && i < 400) begin
            step();
            i++;
        end
        chk($sformatf("u%0d.done_in_time", k), 32'(bs[k]), 32'd0);
    endtask

    task automatic wait_tv(int k);
        int i;
        i = 0;
        while (!tv[k] && i < 100) begin
            step();
            i++;
        end
        chk($sformatf("u%0d.tv_in_time", k), 32'(tv[k]), 32'd1);
    endtask

    task automatic expect_bytes(string nm, int k, int base, logic [47:0] v, int n);
        chk({nm, ".count"}, 32'(cap[k].size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < cap[k].size())
                chk($sformatf("%s.byte%0d", nm, i), 32'(cap[k][base+i]), 32'(v[8*i +: 8]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int fbase;
        rdy_mode = 0;
        en = 2'b01;
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        chk("reset.tx_valid", 32'(tv), 32'd0);
        chk("reset.tx_data", 32'(td[0]), 32'd0);
        chk("reset.result_q", oq[0], 32'd0);
        chk("reset.busy", 32'(bs), 32'd0);
        rst = 1'b1;
        idle(2);

        // 100 / 7
        base = cap[0].size();
        send_frame(48'h0007_0064, 4);
        wait_done(0);
        expect_bytes("d100_7", 0, base, 48'h0002_000E, 4);
        chk("d100_7.q", oq[0], 32'd14);
        chk("d100_7.r", orr[0], 32'd2);
        chk("d100_7.dz", 32'(dz[0]), 32'd0);
        chk("d100_7.latency", 32'(ftx[0] - lrx[0]), 32'd17);

        // divide by zero
        base = cap[0].size();
        send_frame(48'h0000_1234, 4);
        wait_done(0);
        expect_bytes("dzero", 0, base, 48'h1234_FFFF, 4);
        chk("dzero.dz", 32'(dz[0]), 32'd1);
        chk("dzero.latency", 32'(ftx[0] - lrx[0]), 32'd2);

        // 0xFFFF / 1 with a slow transmitter
        base = cap[0].size();
        rdy_mode = 1;
        send_frame(48'h0001_FFFF, 4);
        wait_done(0);
        rdy_mode = 0;
        expect_bytes("dslow", 0, base, 48'h0000_FFFF, 4);

        // inter-byte timeout, then a clean 10 / 3
        base = cap[0].size();
        fbase = fe_cnt[0];
        send_frame(48'h0000_0003, 2);
        idle(GAP + 5);
        chk("tmo.pulses", 32'(fe_cnt[0] - fbase), 32'd1);
        chk("tmo.no_tx", 32'(cap[0].size() - base), 32'd0);
        chk("tmo.idle", 32'(bs[0]), 32'd0);
        send_frame(48'h0003_000A, 4);
        wait_done(0);
        expect_bytes("d10_3", 0, base, 48'h0001_0003, 4);

        // bytes arriving during DIV and TX are dropped
        base = cap[0].size();
        send_frame(48'h0009_00C8, 4);
        send(8'h55);
        send(8'hAA);
        rdy_mode = 3;
        txr = 1'b0;
        wait_tv(0);
        send(8'h77);
        send(8'h01);
        rdy_mode = 0;
        wait_done(0);
        expect_bytes("dinj", 0, base, 48'h0002_0016, 4);
        chk("dinj.q", oq[0], 32'd22);
        chk("dinj.r", orr[0], 32'd2);

        // reset in the middle of a transmit
        send_frame(48'h0003_0050, 4);
        rdy_mode = 3;
        txr = 1'b0;
        wait_tv(0);
        txr = 1'b1;
        step();
        txr = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_tx.tx_valid", 32'(tv[0]), 32'd0);
        chk("rst_tx.tx_data", 32'(td[0]), 32'd0);
        chk("rst_tx.result_q", oq[0], 32'd0);
        chk("rst_tx.result_r", orr[0], 32'd0);
        chk("rst_tx.busy", 32'(bs[0]), 32'd0);
        idle(2);
        rst = 1'b1;
        rdy_mode = 0;
        base = cap[0].size();
        idle(30);
        chk("rst_tx.no_more", 32'(cap[0].size() - base), 32'd0);

        // OP_BYTES=3: 1000000 / 1000
        en = 2'b10;
        base = cap[1].size();
        send_frame(48'h0003E8_0F4240, 6);
        wait_done(1);
        expect_bytes("d3_1e6", 1, base, 48'h000000_0003E8, 6);
        chk("d3_1e6.q", oq[1], 32'd1000);
        chk("d3_1e6.r", orr[1], 32'd0);
        chk("d3_1e6.latency", 32'(ftx[1] - lrx[1]), 32'd25);

        // randomized traffic into both instances
        en = 2'b11;
        rdy_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle(GAP + 2);
            end else if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b0;
                idle(1);
                rst = 1'b1;
            end else begin
                rxv = ($urandom_range(0, 2) == 0);
                rxd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                step();
            end
        end
        rxv = 1'b0;
        rdy_mode = 0;
        idle(GAP + 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_div_frame_ctrl.md
Name: uart_div_frame_ctrl

Overview:
- Byte-stream controller between a UART receiver and a UART transmitter.
- Collects two unsigned operands A and B of OP_BYTES bytes each and computes A / B with an internal sequential restoring divider.
- Returns quotient then remainder as a byte stream over a valid/ready handshake.
- Generalises the fixed 16-bit divide controller: parametrised operand width, real handshaking, inter-byte timeout and divide-by-zero reporting.

Parameters:
- OP_BYTES, 2: bytes per operand. Operand width W = 8*OP_BYTES, a derived localparam. Legal range 1..4.
- GAP_TIMEOUT, 1000000: max clk cycles allowed between received bytes of one frame before it is discarded. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte this cycle
- tx_valid  out  1  tx_data holds a byte to send
- tx_data  out  8  byte to send
- result_q  out  W  last quotient (for LEDs/debug)
- result_r  out  W  last remainder
- div_zero  out  1  last operation had B == 0
- frame_err  out  1  one-cycle pulse on inter-byte timeout
- busy  out  1  high in DIV or TX state

Behaviour:
- Reset (async, rst low):
  - State goes to IDLE; all counters clear.
  - Every output is 0: tx_valid, tx_data, result_q, result_r, div_zero, frame_err, busy.
  - Reset mid-frame, mid-divide or mid-transmit abandons the operation; no partial bytes are emitted afterwards.
- Byte order: little-endian throughout.
  - RX frame: A byte0..byte(N-1), then B byte0..byte(N-1), with N = OP_BYTES.
  - TX frame: Q byte0..byte(N-1), then R byte0..byte(N-1).
- FSM states: IDLE, RX, DIV, TX.
  - IDLE: rx_valid stores the byte into A[7:0], sets byte_cnt=1, moves to RX.
  - RX: each rx_valid stores the byte at position byte_cnt (lower N positions go to A, upper N to B) and increments byte_cnt.
  - RX: the cycle the byte with byte_cnt = 2N-1 is stored, move to DIV.
  - RX: gap counter clears on every rx_valid. If it reaches GAP_TIMEOUT-1 without a byte, pulse frame_err for 1 cycle, drop partial operands, return to IDLE.
  - DIV, B ≠ 0: restoring division, MSB first, one quotient bit per clk, exactly W cycles. Then result_q/result_r/div_zero update in the same cycle; div_zero=0; move to TX.
  - DIV, B == 0: 1 cycle only. Q = all ones, R = A, div_zero=1; move to TX.
  - TX: tx_valid=1 with the current byte on tx_data. A byte transfers on any cycle with tx_valid && tx_ready.
  - TX: tx_data/tx_valid stay stable until transfer; next byte is presented on the following cycle.
  - TX: after the 2N-th transfer, tx_valid drops and the FSM returns to IDLE in the next cycle.
- rx_valid in DIV or TX is ignored; bytes are dropped and not counted.
- busy = (state==DIV || state==TX).
- Latency, from the rx_valid cycle of the last byte:
  - DIV occupies the next W cycles (1 cycle if B==0).
  - tx_valid rises the cycle after DIV completes.
- result_q/result_r/div_zero hold until the next DIV completion or reset. frame_err does not alter them.
- Arithmetic: all unsigned, W-bit. The divider uses a W+1-bit partial remainder; no truncation of A or B.

Test Plan:
- OP_BYTES=2, tx_ready=1: send 0x64,0x00,0x07,0x00 (100/7).
  - Expect tx bytes 0x0E,0x00,0x02,0x00; result_q=14, result_r=2, div_zero=0.
  - Expect first tx_valid 17 cycles after the last rx_valid.
- Send 0x34,0x12,0x00,0x00 (B=0).
  - Expect tx 0xFF,0xFF,0x34,0x12; div_zero=1; DIV lasts 1 cycle.
- Send 0xFF,0xFF,0x01,0x00 with tx_ready toggling 1-of-3 cycles.
  - Expect tx 0xFF,0xFF,0x00,0x00, each byte held stable until accepted; exactly 4 transfers.
- Send 2 bytes, then idle for GAP_TIMEOUT cycles.
  - Expect a single frame_err pulse, state IDLE, no tx_valid.
  - Then send a full 10/3 frame; expect 0x03,0x00,0x01,0x00.
- Inject rx_valid bytes during DIV and TX; expect them ignored and results unchanged. Assert rst mid-TX; expect all outputs 0 at once and no further tx_valid.
- OP_BYTES=3: send 0x40,0x42,0x0F,0xE8,0x03,0x00 (1000000/1000).
  - Expect tx 0xE8,0x03,0x00,0x00,0x00,0x00; DIV 24 cycles.
